// File: rtl/fir_pkg.sv
// Shared sizing constants for the moving-average FIR filter.
package fir_pkg;

   localparam int unsigned WIDTH     = 24;
   localparam int unsigned LOG2_TAPS = 3;
   localparam int unsigned TAPS      = 32'd1 << LOG2_TAPS;
   localparam int unsigned SUM_WIDTH = WIDTH + LOG2_TAPS;

endpackage : fir_pkg

// File: rtl/fir_filter_if.sv
// Sample bus between a sample source (master) and the FIR filter (slave).
interface fir_filter_if #(
   parameter int unsigned WIDTH = fir_pkg::WIDTH
);

   logic [WIDTH-1:0] IN;
   logic [WIDTH-1:0] OUT;

   modport master (output IN, input  OUT);
   modport slave  (input  IN, output OUT);

endinterface : fir_filter_if

// File: rtl/fir_filter_variable_flip_flop.sv
// WIDTH-bit D register with asynchronous active-low clear; one delay-line tap.
module variable_flip_flop #(
   parameter int unsigned WIDTH = fir_pkg::WIDTH
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Q <= '0;
      end else begin
         Q <= D;
      end
   end

endmodule : variable_flip_flop

// File: rtl/fir_filter.sv
// Moving average of the last 2**LOG2_TAPS samples: shift-register taps,
// full-precision adder, truncating power-of-two divide.
module fir_filter #(
   parameter int unsigned WIDTH     = fir_pkg::WIDTH,
   parameter int unsigned LOG2_TAPS = fir_pkg::LOG2_TAPS
) (
   input  logic         CLK,
   input  logic         RST_N,
   fir_filter_if.slave  bus
);

   localparam int unsigned TAPS      = 32'd1 << LOG2_TAPS;
   localparam int unsigned SUM_WIDTH = WIDTH + LOG2_TAPS;

   logic [WIDTH-1:0]     tap_d [TAPS];
   logic [WIDTH-1:0]     tap_q [TAPS];
   logic [SUM_WIDTH-1:0] sum_c;

   // Delay line: tap0 takes the new sample, each later tap takes its predecessor.
   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      if (k == 0) begin : g_head
         assign tap_d[k] = bus.IN;
      end else begin : g_body
         assign tap_d[k] = tap_q[k-1];
      end

      variable_flip_flop #(
         .WIDTH (WIDTH)
      ) u_tap (
         .CLK   (CLK),
         .RST_N (RST_N),
         .D     (tap_d[k]),
         .Q     (tap_q[k])
      );
   end

   // Sum is wide enough for TAPS full-scale samples, so it never wraps.
   always_comb begin
      sum_c = '0;
      for (int unsigned k = 0; k < TAPS; k++) begin
         sum_c = sum_c + SUM_WIDTH'(tap_q[k]);
      end
   end

   assign bus.OUT = WIDTH'(sum_c >> LOG2_TAPS);

endmodule : fir_filter

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: a sliding-window reference plus fixed expected values.
module tb_fir_filter;
   import fir_pkg::*;

   localparam int unsigned W      = fir_pkg::WIDTH;
   localparam int unsigned TAPS_N = fir_pkg::TAPS;

   logic CLK = 1'b0;
   logic RST_N;

   fir_filter_if #(.WIDTH(W)) bus ();

   fir_filter #(
      .WIDTH     (W),
      .LOG2_TAPS (LOG2_TAPS)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int unsigned      n_cmp = 0;
   int unsigned      n_err = 0;
   logic [W-1:0]     model [TAPS_N];
   logic [W-1:0]     exp_q [$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < TAPS_N; i++) model[i] = '0;
   endtask

   // Drive one sample, queue the window average it should produce, check after the edge.
   task automatic drive(input logic [W-1:0] v, input string tag);
      logic [SUM_WIDTH-1:0] s;
      @(negedge CLK);
      bus.IN = v;
      for (int i = TAPS_N - 1; i > 0; i--) model[i] = model[i-1];
      model[0] = v;
      s = '0;
      for (int i = 0; i < TAPS_N; i++) s = s + SUM_WIDTH'(model[i]);
      exp_q.push_back(W'(s >> LOG2_TAPS));
      @(posedge CLK);
      #1;
      if (exp_q.size() == 0) begin
         check_val({tag, "_noexp"}, 32'(bus.OUT), 32'hDEAD_BEEF);
      end else begin
         check_val(tag, 32'(bus.OUT), 32'(exp_q.pop_front()));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N  = 1'b0;
      bus.IN = '0;
      model_clear();
      #12;
      check_val("reset_out", 32'(bus.OUT), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      // Step to 8, then step to 16
      for (int k = 0; k < 12; k++) drive(W'(8), "step8");
      check_val("step8_settle", 32'(bus.OUT), 32'd8);
      for (int k = 0; k < 10; k++) drive(W'(16), "step16");
      check_val("step16_settle", 32'(bus.OUT), 32'd16);

      // Asynchronous reset between edges, held across an edge, then released
      @(posedge CLK);
      #3;
      RST_N = 1'b0;
      model_clear();
      #1;
      check_val("async_rst", 32'(bus.OUT), 32'd0);
      bus.IN = W'(77);
      @(posedge CLK);
      #1;
      check_val("rst_hold", 32'(bus.OUT), 32'd0);
      #1;
      RST_N = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         drive(W'(16), "rst_ramp");
         check_val("rst_ramp_val", 32'(bus.OUT), 32'(2 * k));
      end

      // Impulses: 1 truncates to 0, 8 gives 1 for exactly 8 edges
      for (int k = 0; k < 8; k++) drive('0, "flush");
      drive(W'(1), "imp1");
      for (int k = 0; k < 9; k++) drive('0, "imp1_tail");
      drive(W'(8), "imp8");
      for (int k = 0; k < 9; k++) drive('0, "imp8_tail");

      // Full scale
      for (int k = 0; k < 10; k++) drive('1, "full");
      check_val("full_scale", 32'(bus.OUT), 32'h00FF_FFFF);
      for (int k = 0; k < 8; k++) drive('0, "full_flush");

      // Divider: steady 0xE00005 and one 0xE00005 among zeros
      for (int k = 0; k < 8; k++) drive(W'(24'hE00005), "div_fill");
      check_val("div_steady", 32'(bus.OUT), 32'h00E0_0005);
      for (int k = 0; k < 8; k++) drive('0, "div_flush");
      drive(W'(24'hE00005), "div_single");
      check_val("div_shift", 32'(bus.OUT), 32'h001C_0000);
      for (int k = 0; k < 8; k++) drive('0, "div_tail");

      // Random samples against the reference window
      for (int k = 0; k < 40; k++) drive(W'($urandom), "rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_fir_filter

// File: doc/fir_filter.md
FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 Parameter WIDTH, default 24, SHALL set the sample width in bits of input, output and every tap register.
REQ-002 Parameter LOG2_TAPS, default 3, SHALL set the tap count to 2**LOG2_TAPS (8 taps at default).
REQ-003 Port CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port IN  input  WIDTH  SHALL be the unsigned input sample, sampled every rising CLK edge.
REQ-006 Port OUT  output  WIDTH  SHALL be the unsigned moving average of the last 8 registered samples.

Function
REQ-007 The block SHALL hold an 8-stage delay line of WIDTH-bit registers, tap0..tap7.
REQ-008 On each rising CLK edge with RST_N high, tap0 SHALL load IN and tap(k) SHALL load tap(k-1) for k=1..7; no enable, every edge shifts.
REQ-009 The block SHALL form the sum of tap0..tap7 at full precision, WIDTH+LOG2_TAPS bits (27 at default), with no overflow or wrap.
REQ-010 OUT SHALL equal the sum logically shifted right by LOG2_TAPS, truncated toward zero, with no rounding, keeping the low WIDTH bits.
REQ-011 The divider SHALL be a pure unsigned logical right shift, e.g. 0xE00005 >> 3 = 0x1C0000; zero-fill from the MSB side, no sign extension.
REQ-012 OUT SHALL be combinational from the tap registers, with no output register.
REQ-013 Latency: a change on IN SHALL first affect OUT after 1 rising edge and be fully reflected after 8 rising edges.
REQ-014 Step response: from all-zero taps with constant IN=V, OUT after k edges (k<=8) SHALL be floor(k*V/8), then remain V.
REQ-015 Full-scale case: all taps = 2**WIDTH-1 SHALL give OUT = 2**WIDTH-1, with no overflow.
REQ-016 Inputs SHALL be treated as unsigned; no saturation logic is required or permitted.

Reset
REQ-017 RST_N low SHALL clear tap0..tap7 to 0 immediately, independent of CLK; OUT SHALL therefore read 0 without waiting for an edge.
REQ-018 While RST_N is low, taps SHALL stay 0 regardless of IN or CLK.
REQ-019 On RST_N deassertion, the first rising edge SHALL load IN into tap0 normally.
REQ-020 Reset asserted mid-operation SHALL discard all history; on release, averaging restarts from zero taps.

Structure
REQ-021 WIDTH and LOG2_TAPS defaults SHALL live in a shared package (fir_pkg), together with the derived constants TAPS and SUM_WIDTH.
REQ-022 The tap register SHALL be one parameterised sub-module, variable_flip_flop (WIDTH-bit D register, CLK, RST_N, D, Q), instantiated 8 times.
REQ-023 The divide-by-8 shift and the adder tree SHALL be inline logic in fir_filter; no further sub-modules.

Verification
REQ-024 Reset then IN=8 constant -> OUT = 1,2,...,8 after edges 1..8, then stays 8.
REQ-025 After OUT has settled at 8, IN=16 -> OUT = 9,10,...,16 on the next 8 edges, then stays 16.
REQ-026 Impulse: IN=0x000001 for one edge, then 0 -> OUT = 0 throughout (truncation); IN=0x000008 for one edge, then 0 -> OUT = 1 for exactly 8 edges, then 0.
REQ-027 Full scale: IN=0xFFFFFF for 8+ edges -> OUT = 0xFFFFFF, with no wrap to a small value.
REQ-028 Divider/shift check: taps loaded with 0xE00005 for 8 edges -> OUT = 0xE00005; a single 0xE00005 sample among zeros -> OUT = 0x1C0000.
REQ-029 Assert RST_N low between clock edges while OUT=16 -> OUT = 0 before the next edge; on release with IN=16 -> ramp 2,4,...,16 over 8 edges.
